register_file: RTL

Architectural register block of the 6502 core. Holds A, X, Y, SP, the status register F and the memory-data latch M, and presents all six as registered outputs to the ALU operand mux. Accepts write-back from the ALU result or the data bus, performs stack-pointer increment/decrement and flag updates, and freezes completely while the core is stalled.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/register_file_if.sv | 38 +++
 rtl/status_register.sv | 55 +++++
 rtl/register_file.sv | 90 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 core: register-select codes (also used by
// the ALU operand mux), status bit positions, flag_op codes, reset defaults.
package cpu_pkg;

  // Destination / source register select
  typedef enum logic [2:0] {
    SEL_A     = 3'b000,
    SEL_F     = 3'b001,
    SEL_M     = 3'b010,
    SEL_SP    = 3'b011,
    SEL_X     = 3'b100,
    SEL_Y     = 3'b101,
    SEL_NONE0 = 3'b110,
    SEL_NONE1 = 3'b111
  } reg_sel_e;

  // Explicit flag set/clear instructions
  typedef enum logic [2:0] {
    FOP_NONE = 3'b000,
    FOP_CLC  = 3'b001,
    FOP_SEC  = 3'b010,
    FOP_CLI  = 3'b011,
    FOP_SEI  = 3'b100,
    FOP_CLD  = 3'b101,
    FOP_SED  = 3'b110,
    FOP_CLV  = 3'b111
  } flag_op_e;

  // Status register bit positions: N V 1 B D I Z C
  localparam int unsigned ST_C = 0;
  localparam int unsigned ST_Z = 1;
  localparam int unsigned ST_I = 2;
  localparam int unsigned ST_D = 3;
  localparam int unsigned ST_B = 4;
  localparam int unsigned ST_U = 5;
  localparam int unsigned ST_V = 6;
  localparam int unsigned ST_N = 7;

  // Bit positions of {N,V,Z,C} inside flag_we / alu_flags
  localparam int unsigned FW_C = 0;
  localparam int unsigned FW_Z = 1;
  localparam int unsigned FW_V = 2;
  localparam int unsigned FW_N = 3;

  localparam logic [7:0] SP_RESET_DEFAULT = 8'hFD;
  localparam logic [7:0] F_RESET_DEFAULT  = 8'h24;

  // Bit 5 is hard-wired to 1 and B to 0 in the stored status value;
  // B only exists on the stack image built by the push logic.
  function automatic logic [7:0] fix_status(input logic [7:0] v);
    logic [7:0] r;
    r       = v;
    r[ST_U] = 1'b1;
    r[ST_B] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Control/data bundle between the core sequencer (master) and the
// architectural register file (slave).
interface register_file_if;
  import cpu_pkg::*;

  logic       hold;
  logic       wr_en;
  reg_sel_e   wr_sel;
  logic       wr_src;
  logic [7:0] alu_result;
  logic [7:0] data_in;
  logic       m_load;
  logic [3:0] flag_we;
  logic [3:0] alu_flags;
  flag_op_e   flag_op;
  logic       sp_inc;
  logic       sp_dec;

  logic [7:0] a;
  logic [7:0] f;
  logic [7:0] m;
  logic [7:0] sp;
  logic [7:0] x;
  logic [7:0] y;

  modport master (
    output hold, wr_en, wr_sel, wr_src, alu_result, data_in, m_load,
           flag_we, alu_flags, flag_op, sp_inc, sp_dec,
    input  a, f, m, sp, x, y
  );

  modport slave (
    input  hold, wr_en, wr_sel, wr_src, alu_result, data_in, m_load,
           flag_we, alu_flags, flag_op, sp_inc, sp_dec,
    output a, f, m, sp, x, y
  );

endinterface

// File: rtl/status_register.sv
// Processor status register F: per-bit priority between a full write
// (PLP/RTI), explicit flag instructions and ALU flag updates.
module status_register
  import cpu_pkg::*;
#(
  parameter logic [7:0] F_RESET = F_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       full_we,
  input  logic [7:0] full_data,
  input  flag_op_e   flag_op,
  input  logic [3:0] flag_we,
  input  logic [3:0] alu_flags,
  output logic [7:0] f
);

  logic [7:0] f_q;
  logic [7:0] f_d;

  // Next status: lowest priority applied first so later stages override
  always_comb begin
    f_d = f_q;
    if (!hold) begin
      if (flag_we[FW_N]) f_d[ST_N] = alu_flags[FW_N];
      if (flag_we[FW_V]) f_d[ST_V] = alu_flags[FW_V];
      if (flag_we[FW_Z]) f_d[ST_Z] = alu_flags[FW_Z];
      if (flag_we[FW_C]) f_d[ST_C] = alu_flags[FW_C];

      case (flag_op)
        FOP_CLC: f_d[ST_C] = 1'b0;
        FOP_SEC: f_d[ST_C] = 1'b1;
        FOP_CLI: f_d[ST_I] = 1'b0;
        FOP_SEI: f_d[ST_I] = 1'b1;
        FOP_CLD: f_d[ST_D] = 1'b0;
        FOP_SED: f_d[ST_D] = 1'b1;
        FOP_CLV: f_d[ST_V] = 1'b0;
        default: ;
      endcase

      if (full_we) f_d = full_data;
    end
    f_d = fix_status(f_d);
  end

  // Status storage with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) f_q <= fix_status(F_RESET);
    else     f_q <= f_d;
  end

  assign f = f_q;

endmodule

// File: rtl/register_file.sv
// Architectural registers A, X, Y, SP, M of the 6502 core plus the status
// register. All outputs come straight from flops; no write bypass.
module register_file
  import cpu_pkg::*;
#(
  parameter logic [7:0] SP_RESET = SP_RESET_DEFAULT,
  parameter logic [7:0] F_RESET  = F_RESET_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  register_file_if.slave  bus
);

  logic [7:0] a_q,  a_d;
  logic [7:0] x_q,  x_d;
  logic [7:0] y_q,  y_d;
  logic [7:0] sp_q, sp_d;
  logic [7:0] m_q,  m_d;
  logic [7:0] wr_data;
  logic       f_full_we;

  assign wr_data   = bus.wr_src ? bus.data_in : bus.alu_result;
  assign f_full_we = bus.wr_en && (bus.wr_sel == SEL_F);

  // Next-state for A/X/Y/SP/M; explicit writes take precedence over
  // m_load and stack-pointer stepping
  always_comb begin
    a_d  = a_q;
    x_d  = x_q;
    y_d  = y_q;
    sp_d = sp_q;
    m_d  = m_q;
    if (!bus.hold) begin
      if (bus.m_load) m_d = bus.data_in;

      // inc and dec together cancel out
      if (bus.sp_inc && !bus.sp_dec)      sp_d = sp_q + 8'd1;
      else if (bus.sp_dec && !bus.sp_inc) sp_d = sp_q - 8'd1;

      if (bus.wr_en) begin
        case (bus.wr_sel)
          SEL_A:   a_d  = wr_data;
          SEL_M:   m_d  = wr_data;
          SEL_SP:  sp_d = wr_data;
          SEL_X:   x_d  = wr_data;
          SEL_Y:   y_d  = wr_data;
          default: ;  // F handled in status_register, 110/111 write nothing
        endcase
      end
    end
  end

  // Register storage; reset discards any write presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= 8'h00;
      x_q  <= 8'h00;
      y_q  <= 8'h00;
      m_q  <= 8'h00;
      sp_q <= SP_RESET;
    end else begin
      a_q  <= a_d;
      x_q  <= x_d;
      y_q  <= y_d;
      m_q  <= m_d;
      sp_q <= sp_d;
    end
  end

  status_register #(
    .F_RESET (F_RESET)
  ) u_status (
    .clk       (clk),
    .rst       (rst),
    .hold      (bus.hold),
    .full_we   (f_full_we),
    .full_data (wr_data),
    .flag_op   (bus.flag_op),
    .flag_we   (bus.flag_we),
    .alu_flags (bus.alu_flags),
    .f         (bus.f)
  );

  assign bus.a  = a_q;
  assign bus.x  = x_q;
  assign bus.y  = y_q;
  assign bus.sp = sp_q;
  assign bus.m  = m_q;

endmodule
